lane_sensor_decoder: RTL

- Entry-lane front end for the parking lot controller.
- Takes two raw, asynchronous, bouncing optical beam sensors mounted in series across the lane: sensor_a on the street side, sensor_b on the lot side.
- Synchronises and debounces both sensors, then tracks beam-break order with a direction FSM.
- Emits single-cycle car_enter / car_exit pulses, which feed the lot occupancy/gate controller's car_enter / car_exit inputs directly.
- Flags jammed or illegal sensor sequences on sensor_fault.

---
 rtl/lane_sensor_decoder_pkg.sv | 105 ++++++++++
 rtl/lane_sensor_decoder_if.sv | 19 +
 rtl/lane_sensor_decoder_debounce.sv | 51 +++++
 rtl/lane_sensor_decoder.sv | 74 +++++++
 4 files changed

// File: rtl/lane_sensor_decoder_pkg.sv
// Shared types and helpers for the entry-lane sensor decoder.
// The transition table lives here so the FSM stays a single sequential block.
package lane_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENT_A  = 3'd1,
    ENT_AB = 3'd2,
    ENT_B  = 3'd3,
    EXT_B  = 3'd4,
    EXT_AB = 3'd5,
    EXT_A  = 3'd6,
    FAULT  = 3'd7
  } lane_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 50_000_000;

  function automatic logic is_transit(input lane_state_t st);
    logic res;
    res = 1'b0;
    case (st)
      IDLE:    res = 1'b0;
      FAULT:   res = 1'b0;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // Beam-break order table; {a,b} combinations not listed hold the current state.
  function automatic lane_state_t lane_next_state(input lane_state_t st,
                                                  input logic a, input logic b);
    lane_state_t nxt;
    logic [1:0]  ab;
    nxt = st;
    ab  = {a, b};
    case (st)
      IDLE: begin
        case (ab)
          2'b10:   nxt = ENT_A;
          2'b01:   nxt = EXT_B;
          2'b11:   nxt = FAULT;
          default: nxt = IDLE;
        endcase
      end
      ENT_A: begin
        case (ab)
          2'b11:   nxt = ENT_AB;
          2'b00:   nxt = IDLE;
          2'b01:   nxt = FAULT;
          default: nxt = ENT_A;
        endcase
      end
      ENT_AB: begin
        case (ab)
          2'b01:   nxt = ENT_B;
          2'b10:   nxt = ENT_A;
          2'b00:   nxt = FAULT;
          default: nxt = ENT_AB;
        endcase
      end
      ENT_B: begin
        case (ab)
          2'b00:   nxt = IDLE;
          2'b11:   nxt = ENT_AB;
          2'b10:   nxt = FAULT;
          default: nxt = ENT_B;
        endcase
      end
      EXT_B: begin
        case (ab)
          2'b11:   nxt = EXT_AB;
          2'b00:   nxt = IDLE;
          2'b10:   nxt = FAULT;
          default: nxt = EXT_B;
        endcase
      end
      EXT_AB: begin
        case (ab)
          2'b10:   nxt = EXT_A;
          2'b01:   nxt = EXT_B;
          2'b00:   nxt = FAULT;
          default: nxt = EXT_AB;
        endcase
      end
      EXT_A: begin
        case (ab)
          2'b00:   nxt = IDLE;
          2'b11:   nxt = EXT_AB;
          2'b01:   nxt = FAULT;
          default: nxt = EXT_A;
        endcase
      end
      FAULT: begin
        case (ab)
          2'b00:   nxt = IDLE;
          default: nxt = FAULT;
        endcase
      end
      default: nxt = FAULT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/lane_sensor_decoder_if.sv
// Lane sensor bundle: raw beam inputs toward the decoder, vehicle events back out.
interface lane_sensor_decoder_if;
  logic sensor_a_raw;
  logic sensor_b_raw;
  logic car_enter;
  logic car_exit;
  logic busy;
  logic sensor_fault;

  modport master (
    output sensor_a_raw, sensor_b_raw,
    input  car_enter, car_exit, busy, sensor_fault
  );

  modport slave (
    input  sensor_a_raw, sensor_b_raw,
    output car_enter, car_exit, busy, sensor_fault
  );
endinterface

// File: rtl/lane_sensor_decoder_debounce.sv
// One beam channel: 2-flop synchroniser followed by a stability-count debouncer.
module sensor_debounce
  import lane_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          clean_r;
  logic [CW-1:0] cnt_r;

  // Bring the asynchronous beam into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // The clean value flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clean_r <= 1'b0;
      cnt_r   <= '0;
    end else if (sync2_r != clean_r) begin
      if (cnt_r == CNT_LAST) begin
        clean_r <= sync2_r;
        cnt_r   <= '0;
      end else begin
        cnt_r   <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign clean = clean_r;

endmodule

// File: rtl/lane_sensor_decoder.sv
// Entry-lane front end: debounces both beams and decodes vehicle direction,
// producing single-cycle enter/exit pulses and a fault level for jams or bad order.
module lane_sensor_decoder
  import lane_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  lane_sensor_decoder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          a_s;
  logic          b_s;
  lane_state_t   state_r;
  lane_state_t   next_s;
  logic          timeout_hit_s;
  logic [TW-1:0] timeout_r;
  logic          car_enter_r;
  logic          car_exit_r;
  logic          busy_r;
  logic          fault_r;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.sensor_a_raw),
    .clean (a_s)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.sensor_b_raw),
    .clean (b_s)
  );

  // The counter is held at zero outside transit states, so a hit implies transit.
  assign timeout_hit_s = (timeout_r == TO_LAST);
  assign next_s        = timeout_hit_s ? FAULT : lane_next_state(state_r, a_s, b_s);

  // Direction FSM with timeout and registered event/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      timeout_r   <= '0;
      car_enter_r <= 1'b0;
      car_exit_r  <= 1'b0;
      busy_r      <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= next_s;
      car_enter_r <= (state_r == ENT_B) && (next_s == IDLE);
      car_exit_r  <= (state_r == EXT_A) && (next_s == IDLE);
      busy_r      <= is_transit(next_s);
      fault_r     <= (next_s == FAULT);
      if ((next_s != state_r) || !is_transit(state_r)) begin
        timeout_r <= '0;
      end else begin
        timeout_r <= timeout_r + TW'(1);
      end
    end
  end

  assign bus.car_enter    = car_enter_r;
  assign bus.car_exit     = car_exit_r;
  assign bus.busy         = busy_r;
  assign bus.sensor_fault = fault_r;

endmodule
